// File: rtl/latch_motor_if.sv
// Request/status bundle between the platform block and the bin-latch motor responder.
interface latch_motor_if;
  logic       motor_on;
  logic [3:0] GPIO_0;
  logic       busy;
  logic       latch_open;
  logic       done;

  modport master (
    output motor_on,
    input  GPIO_0,
    input  busy,
    input  latch_open,
    input  done
  );

  modport slave (
    input  motor_on,
    output GPIO_0,
    output busy,
    output latch_open,
    output done
  );
endinterface

// File: rtl/latch_motor.sv
// Bin-latch stepper driver: open for OPEN_STEPS phases, dwell, close, pulse done,
// then wait for motor_on to drop before accepting another request.
module latch_motor #(
  parameter int unsigned PHASE_CYCLES = 97_656,
  parameter int unsigned OPEN_STEPS   = 128,
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input logic          clk,
  input logic          rst_n,
  latch_motor_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_DWELL   = 3'd2;
  localparam logic [2:0] ST_CLOSE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [31:0] PHASE_LAST = 32'(PHASE_CYCLES - 1);
  localparam logic [31:0] STEP_LAST  = 32'(OPEN_STEPS - 1);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  logic [2:0]  state;
  logic [31:0] cyc_cnt;
  logic [31:0] step_cnt;
  logic [3:0]  coils;
  logic        busy_q;
  logic        open_q;
  logic        done_q;

  // cyc_cnt times both the phase hold and the dwell; the states never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      step_cnt <= '0;
      coils    <= '0;
      busy_q   <= 1'b0;
      open_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.motor_on) begin
            state    <= ST_OPEN;
            coils    <= 4'b1000;
            busy_q   <= 1'b1;
            cyc_cnt  <= '0;
            step_cnt <= '0;
          end
        end

        ST_OPEN: begin
          if (cyc_cnt == PHASE_LAST) begin
            cyc_cnt <= '0;
            if (step_cnt == STEP_LAST) begin
              state    <= ST_DWELL;
              coils    <= '0;
              open_q   <= 1'b1;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 32'd1;
              coils    <= {coils[0], coils[3:1]};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        ST_DWELL: begin
          if (cyc_cnt == DWELL_LAST) begin
            cyc_cnt <= '0;
            state   <= ST_CLOSE;
            coils   <= 4'b0001;
            open_q  <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        ST_CLOSE: begin
          if (cyc_cnt == PHASE_LAST) begin
            cyc_cnt <= '0;
            if (step_cnt == STEP_LAST) begin
              state    <= ST_RELEASE;
              coils    <= '0;
              done_q   <= 1'b1;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 32'd1;
              coils    <= {coils[2:0], coils[3]};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        ST_RELEASE: begin
          if (!bus.motor_on) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          coils  <= '0;
          busy_q <= 1'b0;
          open_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GPIO_0     = coils;
  assign bus.busy       = busy_q;
  assign bus.latch_open = open_q;
  assign bus.done       = done_q;

endmodule
